// File: rtl/cdma_pkg.sv
// cdma_pkg: shared state encoding, code width and reset codes for the CDMA transmit scheduler
package cdma_pkg;
  localparam int CODE_W = 6;
  localparam logic [CODE_W-1:0] CODE1_RST = 6'h2B;
  localparam logic [CODE_W-1:0] CODE2_RST = 6'h17;
  typedef enum logic [1:0] {IDLE, SPREAD, GUARD} state_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-requester round-robin arbiter; last_i = 1 means user 2 was granted last
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       last_i,
  output logic [1:0] grant_o,
  output logic       last_o
);
  assign grant_o[0] = en_i & req_i[0] & (~req_i[1] | last_i);
  assign grant_o[1] = en_i & req_i[1] & (~req_i[0] | ~last_i);
  assign last_o = |grant_o ? grant_o[1] : last_i;
endmodule

// File: rtl/cdma_tx_scheduler.sv
// cdma_tx_scheduler: round-robin bit scheduler for the two-user spreader, with guard chips
// and code registers that only change between bits.
module cdma_tx_scheduler
  import cdma_pkg::*;
#(
  parameter int CHIPS_PER_BIT = 63,
  parameter int GUARD_CHIPS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              u1_valid,
  input  logic              u1_bit,
  output logic              u1_ready,
  input  logic              u2_valid,
  input  logic              u2_bit,
  output logic              u2_ready,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [CODE_W-1:0] cfg_code,
  output logic [CODE_W-1:0] user_code_1,
  output logic [CODE_W-1:0] user_code_2,
  output logic              tx_bit,
  output logic              tx_user_sel,
  output logic              tx_active,
  output logic              bit_start,
  output logic [5:0]        chip_idx
);
  localparam logic [5:0] C_LAST = 6'(CHIPS_PER_BIT - 1);
  localparam logic [3:0] G_LAST = 4'(GUARD_CHIPS > 0 ? GUARD_CHIPS - 1 : 0);
  state_e            state_q, state_d;
  logic [5:0]        chip_q, chip_d;
  logic [3:0]        guard_q, guard_d;
  logic              rr_last_q, rr_last_d;
  logic              tx_bit_q, tx_bit_d, tx_sel_q, tx_sel_d;
  logic [CODE_W-1:0] code1_q, code1_d, code2_q, code2_d;
  logic [CODE_W-1:0] pend1_q, pend1_d, pend2_q, pend2_d;
  logic [1:0]        grant;
  logic              idle;
  assign idle = state_q == IDLE;
  rr_arbiter_2 u_arb (
    .req_i  ({u2_valid, u1_valid}),
    .en_i   (idle),
    .last_i (rr_last_q),
    .grant_o(grant),
    .last_o (rr_last_d)
  );
  assign u1_ready    = grant[0];
  assign u2_ready    = grant[1];
  assign tx_active   = state_q == SPREAD;
  assign bit_start   = tx_active && chip_q == 6'd0;
  assign chip_idx    = chip_q;
  assign tx_bit      = tx_bit_q;
  assign tx_user_sel = tx_sel_q;
  assign user_code_1 = code1_q;
  assign user_code_2 = code2_q;
  always_comb begin
    state_d  = state_q;
    chip_d   = chip_q;
    guard_d  = guard_q;
    tx_bit_d = tx_bit_q;
    tx_sel_d = tx_sel_q;
    case (state_q)
      IDLE: if (|grant) begin
        state_d  = SPREAD;
        chip_d   = 6'd0;
        tx_bit_d = grant[1] ? u2_bit : u1_bit;
        tx_sel_d = grant[1];
      end
      SPREAD: if (chip_q == C_LAST) begin
        state_d = GUARD_CHIPS == 0 ? IDLE : GUARD;
        chip_d  = 6'd0;
        guard_d = 4'd0;
      end else begin
        chip_d = chip_q + 6'd1;
      end
      GUARD: begin
        guard_d = guard_q + 4'd1;
        state_d = guard_q == G_LAST ? IDLE : GUARD;
      end
      default: state_d = IDLE;
    endcase
  end
  // Zero is not a usable code, so such writes are dropped; active codes only load while idle.
  always_comb begin
    pend1_d = (cfg_we && !cfg_sel && cfg_code != '0) ? cfg_code : pend1_q;
    pend2_d = (cfg_we && cfg_sel && cfg_code != '0) ? cfg_code : pend2_q;
    code1_d = idle ? pend1_d : code1_q;
    code2_d = idle ? pend2_d : code2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      chip_q    <= 6'd0;
      guard_q   <= 4'd0;
      rr_last_q <= 1'b1;
      tx_bit_q  <= 1'b0;
      tx_sel_q  <= 1'b0;
      code1_q   <= CODE1_RST;
      code2_q   <= CODE2_RST;
      pend1_q   <= CODE1_RST;
      pend2_q   <= CODE2_RST;
    end else begin
      state_q   <= state_d;
      chip_q    <= chip_d;
      guard_q   <= guard_d;
      rr_last_q <= rr_last_d;
      tx_bit_q  <= tx_bit_d;
      tx_sel_q  <= tx_sel_d;
      code1_q   <= code1_d;
      code2_q   <= code2_d;
      pend1_q   <= pend1_d;
      pend2_q   <= pend2_d;
    end
  end
endmodule
